// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, status bit indices and trap cause codes
package alu_pkg;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_DIV = 4'd4;
  localparam logic [3:0] ALU_MUL = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_LW  = 4'd12;
  localparam logic [3:0] ALU_LH  = 4'd13;
  localparam int ST_ZERO    = 7;
  localparam int ST_MUL_OVF = 6;
  localparam int ST_CARRY   = 5;
  localparam int ST_NEG     = 4;
  localparam int ST_ALIGNED = 3;
  localparam int ST_DIV0    = 2;
  localparam logic [7:0] FLAG_MASK = 8'hFC;
  typedef enum logic [2:0] {
    CAUSE_NONE       = 3'd0,
    CAUSE_DIV0       = 3'd1,
    CAUSE_MISALIGN_W = 3'd2,
    CAUSE_MISALIGN_H = 3'd3,
    CAUSE_MUL_OVF    = 3'd4,
    CAUSE_OVF        = 3'd5
  } cause_e;
  typedef enum logic {IDLE, PENDING} state_e;
endpackage

// File: rtl/alu_trap_prio.sv
// alu_trap_prio: fixed-priority trap cause encoder for one ALU operation
module alu_trap_prio
  import alu_pkg::*;
#(
  parameter logic OVF_TRAP_EN = 1'b1,
  parameter logic MUL_TRAP_EN = 1'b1
) (
  input  logic [3:0] control,
  input  logic       div0,
  input  logic       aligned,
  input  logic       mul_ovf,
  input  logic       carry,
  output cause_e     cause
);
  always_comb
    cause = (control == ALU_DIV && div0)                            ? CAUSE_DIV0       :
            (control == ALU_LW && !aligned)                         ? CAUSE_MISALIGN_W :
            (control == ALU_LH && !aligned)                         ? CAUSE_MISALIGN_H :
            (MUL_TRAP_EN && control == ALU_MUL && mul_ovf)          ? CAUSE_MUL_OVF    :
            (OVF_TRAP_EN && (control == ALU_ADD || control == ALU_SUB) && carry) ? CAUSE_OVF :
                                                                      CAUSE_NONE;
endmodule

// File: rtl/alu_exception_unit.sv
// alu_exception_unit: captures ALU traps, holds them until acknowledged, tracks sticky flags
module alu_exception_unit
  import alu_pkg::*;
#(
  parameter logic OVF_TRAP_EN = 1'b1,
  parameter logic MUL_TRAP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [3:0]  control,
  input  logic [7:0]  status,
  input  logic [31:0] result,
  input  logic [31:0] pc,
  input  logic        ack,
  input  logic        clr,
  output logic        exc_req,
  output logic [2:0]  exc_cause,
  output logic [31:0] epc,
  output logic [31:0] badaddr,
  output logic        flush,
  output logic        busy,
  output logic [7:0]  flags_q,
  output logic [7:0]  exc_count
);
  state_e state, state_n;
  cause_e cause;
  logic   accept, trap;
  alu_trap_prio #(.OVF_TRAP_EN(OVF_TRAP_EN), .MUL_TRAP_EN(MUL_TRAP_EN)) u_prio (
    .control(control),
    .div0   (status[ST_DIV0]),
    .aligned(status[ST_ALIGNED]),
    .mul_ovf(status[ST_MUL_OVF]),
    .carry  (status[ST_CARRY]),
    .cause  (cause)
  );
  assign accept  = valid && state == IDLE;
  assign trap    = accept && cause != CAUSE_NONE;
  assign exc_req = state == PENDING;
  assign busy    = state == PENDING;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (trap ? PENDING : IDLE) : (ack ? IDLE : PENDING);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // Cause/epc/badaddr load only on trap entry so they stay frozen while pending
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      exc_cause <= 3'd0;
      epc       <= 32'd0;
      badaddr   <= 32'd0;
      flush     <= 1'b0;
      flags_q   <= 8'd0;
      exc_count <= 8'd0;
    end else begin
      flush   <= trap;
      flags_q <= (clr ? 8'd0 : flags_q) | (accept ? (status & FLAG_MASK) : 8'd0);
      if (trap) begin
        exc_cause <= cause;
        epc       <= pc;
        badaddr   <= result;
        if (exc_count != 8'hFF) exc_count <= exc_count + 8'd1;
      end else if (state == PENDING && ack) exc_cause <= 3'd0;
    end
endmodule

// File: doc/alu_exception_unit.md
ALU_EXCEPTION_UNIT -- requirements
Module: alu_exception_unit

Interface
REQ-001 SHALL have parameter OVF_TRAP_EN, default 1, enabling traps on add/sub carry-out (status bit 5).
REQ-002 SHALL have parameter MUL_TRAP_EN, default 1, enabling traps on multiply overflow (status bit 6).
REQ-003 SHALL have ports in this order: clk  in  1  single clock, rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 valid  in  1  ALU operation in EX is valid this cycle.
REQ-006 control  in  4  ALU control code of that operation.
REQ-007 status  in  8  ALU status bus: [7] zero, [6] mul overflow, [5] carry, [4] negative, [3] aligned, [2] div-by-zero, [1:0] zero.
REQ-008 result  in  32  ALU result; this is the effective address for codes 12 and 13.
REQ-009 pc  in  32  PC of the EX instruction.
REQ-010 ack  in  1  handler acknowledge.
REQ-011 clr  in  1  clear the sticky flags.
REQ-012 exc_req  out  1  exception pending.
REQ-013 exc_cause  out  3  cause code.
REQ-014 epc  out  32  captured PC.
REQ-015 badaddr  out  32  captured result.
REQ-016 flush  out  1  one-cycle pulse on trap entry.
REQ-017 busy  out  1  unit is not accepting operations.
REQ-018 flags_q  out  8  sticky OR of accepted status values.
REQ-019 exc_count  out  8  saturating trap counter.

Function
REQ-020 SHALL implement FSM states IDLE and PENDING; busy = (state == PENDING).
REQ-021 An operation SHALL be accepted only when valid=1 and state=IDLE.
REQ-022 Trap conditions SHALL be evaluated in this fixed priority order, highest first:
- cause 1: div-by-zero, i.e. control=4 and status[2].
- cause 2: misaligned word, i.e. control=12 and !status[3].
- cause 3: misaligned half, i.e. control=13 and !status[3].
- cause 4: MUL_TRAP_EN and control=5 and status[6].
- cause 5: OVF_TRAP_EN and control in {2,6} and status[5].
REQ-023 Cause 0 SHALL mean none; codes 6 and 7 are reserved and SHALL never be produced.
REQ-024 On an accepted operation with a trap condition, the unit SHALL, at the next edge:
- move to PENDING;
- register exc_cause, epc<=pc and badaddr<=result;
- assert exc_req.
REQ-025 flush SHALL be high only for the first cycle of PENDING (registered; one cycle of latency after acceptance).
REQ-026 exc_req SHALL stay high, with exc_cause, epc and badaddr stable, until a cycle in which ack=1 and state=PENDING; at that edge the FSM SHALL return to IDLE and exc_req SHALL fall.
REQ-027 In the ack cycle busy is still 1, so a valid operation presented in that same cycle SHALL be dropped (not accepted, not flagged).
REQ-028 ack while IDLE SHALL be ignored.
REQ-029 After ack, exc_cause SHALL return to 0; epc and badaddr SHALL hold their last values.
REQ-030 flags_q SHALL update each edge as (clr ? 0 : flags_q) | (accepted ? status : 0): clr and an accepted operation in the same cycle leave exactly that operation's status.
REQ-031 Bits [1:0] of flags_q SHALL always be 0.
REQ-032 exc_count SHALL increment on each PENDING entry and saturate at 255.
REQ-033 exc_count SHALL be cleared only by rst.
REQ-034 Accepted operations with no trap condition SHALL only update flags_q; exc_req stays 0.
REQ-035 Codes other than 2, 4, 5, 6, 12 and 13 SHALL never trap.

Reset
REQ-036 While rst=1, asynchronously: state=IDLE, and all outputs (exc_req, exc_cause, epc, badaddr, flush, busy, flags_q, exc_count) SHALL be 0.
REQ-037 rst during PENDING SHALL abort the trap with no ack required.
REQ-038 Operation after reset release SHALL begin at the first rising edge with rst=0.

Structure
REQ-039 ALU control codes, status bit indices and cause codes SHALL be constants in a shared package (alu_pkg) that is also used by the ALU and the control decoder.
REQ-040 The cause priority encoder SHALL be a combinational sub-module named alu_trap_prio; the FSM and registers stay in alu_exception_unit.

Verification
REQ-041 Divide by zero: control=4, status=8'h84, valid, pc=32'h100 -> next cycle exc_req=1, exc_cause=1, epc=32'h100, flush=1 for 1 cycle, exc_count=1.
REQ-042 Misaligned word: control=12, status=8'h00, result=32'h1002 -> cause 2 and badaddr=32'h1002. Same operation with status=8'h08 -> no trap.
REQ-043 Pending hold: in PENDING, drive a new valid div-by-zero and hold ack=0 for 5 cycles -> outputs unchanged; assert ack together with a valid op -> IDLE next cycle, op dropped, flags_q unchanged.
REQ-044 Overflow gating: control=2, status=8'hA0 with OVF_TRAP_EN=0 -> no trap and flags_q=8'hA0; with OVF_TRAP_EN=1 -> cause 5.
REQ-045 Saturation and reset: 256 traps with acks -> exc_count=255; assert rst mid-PENDING -> all outputs 0 immediately, without waiting for a clock edge.
REQ-046 Clear and accept together: clr=1 and an accepted op with status=8'h10 in the same cycle, with flags_q=8'hFC beforehand -> flags_q=8'h10.
